// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative Booth multiplier.
// State and digit encodings plus the step-count function.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } digit_e;

  function automatic int booth_iters(
    input int wb,
    input bit radix4
  );
    return radix4 ? (wb + 2) / 2 : wb + 1;
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Booth digit decode and multiple select (0, +-A, +-2A).
// Radix-2 reuses the radix-4 table with a duplicated multiplier bit.
module booth_recode
  import booth_pkg::*;
#(
  parameter int WA     = 521,
  parameter bit RADIX4 = 1'b1
) (
  input  logic [1:0]    bits,
  input  logic          prev,
  input  logic [WA:0]   a,
  output logic [WA+2:0] mult
);

  logic [2:0]    win;
  digit_e        digit;
  logic [WA+2:0] a1;
  logic [WA+2:0] a2;

  // {b0,b0,prev} maps 00/11 to zero, 01 to +A, 10 to -A
  assign win = RADIX4 ? {bits, prev}
                      : {bits[0], bits[0], prev};

  assign a1 = {{2{a[WA]}}, a};
  assign a2 = {a1[WA+1:0], 1'b0};

  always_comb begin
    digit = ZERO;
    unique case (win)
      3'b001, 3'b010: digit = P1;
      3'b011:         digit = P2;
      3'b100:         digit = M2;
      3'b101, 3'b110: digit = M1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    mult = '0;
    unique case (1'b1)
      digit == P1: mult = a1;
      digit == P2: mult = a2;
      digit == M1: mult = -a1;
      digit == M2: mult = -a2;
      default:     mult = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_param.sv
// Iterative Booth multiplier, radix-2 or radix-4, signed/unsigned
// per operation, valid/ready on both sides, registered outputs.
module booth_seq_param
  import booth_pkg::*;
#(
  parameter int WA     = 521,
  parameter int WB     = 521,
  parameter bit RADIX4 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] c
);

  localparam int N  = booth_iters(WB, RADIX4);
  localparam int S  = RADIX4 ? 2 : 1;
  localparam int MB = N * S;
  localparam int CW = $clog2(N + 1);
  localparam int PW = WA + 3 + MB;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state;
  logic [WA:0]   a_reg;
  logic [WA+2:0] acc;
  logic [WA+2:0] mult;
  logic [WA+2:0] sum;
  logic [MB-1:0] mreg;
  logic          prev;
  logic [CW-1:0] cnt;
  logic [PW-1:0] shifted;
  logic [WA:0]   a_ext;
  logic [MB-1:0] b_ext;

  assign a_ext = {sgn & a[WA-1], a};
  assign b_ext = {{(MB-WB){sgn & b[WB-1]}}, b};

  booth_recode #(
    .WA    (WA),
    .RADIX4(RADIX4)
  ) u_recode (
    .bits(mreg[1:0]),
    .prev(prev),
    .a   (a_reg),
    .mult(mult)
  );

  // {acc,mreg} is the running product; product bits fill mreg from the top
  assign sum     = acc + mult;
  assign shifted = $signed({sum, mreg}) >>> S;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      cnt       <= '0;
      acc       <= '0;
      mreg      <= '0;
      prev      <= 1'b0;
      a_reg     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a_ext;
            mreg     <= b_ext;
            acc      <= '0;
            prev     <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc  <= shifted[PW-1 -: WA+3];
          mreg <= shifted[MB-1:0];
          prev <= mreg[S-1];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            c         <= shifted[WA+WB-1:0];
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_param.sv
// Directed bench: 8x8 radix-2/radix-4 and 521x521 radix-4/radix-2
// instances, each driven through its own handshake.
module tb_booth_seq_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          iv[4], ir[4], ov[4], ordy[4], sg[4];
  logic [7:0]    a8[2], b8[2];
  logic [15:0]   c8[2];
  logic [520:0]  aw[2], bw[2];
  logic [1041:0] cw[2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  vec_t vt[9] = '{
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
    '{8'hFF, 8'hFF, 1'b1, 16'h0001},
    '{8'h7F, 8'h81, 1'b1, 16'hC0FF},
    '{8'h7F, 8'h81, 1'b0, 16'h3FFF},
    '{8'h03, 8'h05, 1'b0, 16'h000F},
    '{8'h00, 8'hFF, 1'b1, 16'h0000},
    '{8'hFF, 8'h01, 1'b1, 16'hFFFF},
    '{8'h80, 8'h7F, 1'b1, 16'hC080},
    '{8'hC8, 8'h0A, 1'b1, 16'hFDD0}
  };

  vec_t bb[4] = '{
    '{8'h80, 8'h80, 1'b1, 16'h4000},
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
    '{8'h03, 8'h05, 1'b0, 16'h000F},
    '{8'hC8, 8'h0A, 1'b1, 16'hFDD0}
  };

  booth_seq_param #(.WA(8), .WB(8), .RADIX4(1'b0)) u_r2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a8[0]), .b(b8[0]), .sgn(sg[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .c(c8[0])
  );

  booth_seq_param #(.WA(8), .WB(8), .RADIX4(1'b1)) u_r4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a8[1]), .b(b8[1]), .sgn(sg[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .c(c8[1])
  );

  booth_seq_param #(.WA(521), .WB(521), .RADIX4(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(aw[0]), .b(bw[0]), .sgn(sg[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .c(cw[0])
  );

  booth_seq_param #(.WA(521), .WB(521), .RADIX4(1'b0)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
    .a(aw[1]), .b(bw[1]), .sgn(sg[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .c(cw[1])
  );

  function automatic int nit(input int d);
    case (d)
      0:       return 9;
      1:       return 5;
      2:       return 261;
      default: return 522;
    endcase
  endfunction

  task automatic run8(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic rdy,
                      output logic [15:0] p, output int lat);
    int k;
    @(negedge clk);
    a8[d] = a; b8[d] = b; sg[d] = s; ordy[d] = rdy; iv[d] = 1'b1;
    k = 0;
    while (ir[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat = 1;
    while (ov[d] !== 1'b1 && lat < 1000) begin @(posedge clk); #1; lat++; end
    p = c8[d];
  endtask

  task automatic runw(input int d, input logic [520:0] a, input logic [520:0] b,
                      input logic s, output logic [1041:0] p, output int lat);
    int k;
    @(negedge clk);
    aw[d-2] = a; bw[d-2] = b; sg[d] = s; ordy[d] = 1'b1; iv[d] = 1'b1;
    k = 0;
    while (ir[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat = 1;
    while (ov[d] !== 1'b1 && lat < 1000) begin @(posedge clk); #1; lat++; end
    p = cw[d-2];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hs d%0d: in_ready=%b out_valid=%b want 1/0", d, ir[d], ov[d]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (c8[d] !== 16'h0) begin
        n_err++;
        $display("FAIL reset_c d%0d: c=%h want 0000", d, c8[d]);
      end
      n_cmp++;
      if (cw[d] !== '0) begin
        n_err++;
        $display("FAIL reset_cw d%0d: c[63:0]=%h want 0", d + 2, cw[d][63:0]);
      end
    end
  endtask

  task automatic test_signed_corner();
    logic [15:0] p;
    int lat;
    for (int d = 0; d < 2; d++) begin
      run8(d, 8'h80, 8'h80, 1'b1, 1'b1, p, lat);
      n_cmp++;
      if (p !== 16'h4000) begin
        n_err++;
        $display("FAIL corner d%0d: c=%h want 4000", d, p);
      end
      n_cmp++;
      if (lat != nit(d) + 1) begin
        n_err++;
        $display("FAIL latency d%0d: got %0d want %0d", d, lat, nit(d) + 1);
      end
    end
  endtask

  task automatic test_vectors();
    logic [15:0] p;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        run8(d, vt[i].a, vt[i].b, vt[i].s, 1'b1, p, lat);
        n_cmp++;
        if (p !== vt[i].p) begin
          n_err++;
          $display("FAIL vec%0d d%0d: %h*%h s=%b c=%h want %h",
                   i, d, vt[i].a, vt[i].b, vt[i].s, p, vt[i].p);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    int lat;
    logic ok;
    for (int d = 0; d < 2; d++) begin
      run8(d, 8'h12, 8'h34, 1'b0, 1'b0, p, lat);
      n_cmp++;
      if (p !== 16'h03A8) begin
        n_err++;
        $display("FAIL bp_value d%0d: c=%h want 03a8", d, p);
      end
      ok = 1'b1;
      repeat (20) begin
        @(posedge clk); #1;
        if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || c8[d] !== 16'h03A8) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL bp_hold d%0d: ov=%b ir=%b c=%h want 1/0/03a8", d, ov[d], ir[d], c8[d]);
      end
      @(negedge clk);
      ordy[d] = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_release d%0d: ir=%b ov=%b want 1/0", d, ir[d], ov[d]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p;
    int lat;
    int k;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      a8[d] = 8'h7F; b8[d] = 8'h81; sg[d] = 1'b1; ordy[d] = 1'b1; iv[d] = 1'b1;
      k = 0;
      while (ir[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      iv[d] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if (ov[d] !== 1'b0 || c8[d] !== 16'h0 || ir[d] !== 1'b1) begin
        n_err++;
        $display("FAIL rst_mid d%0d: ov=%b c=%h ir=%b want 0/0000/1", d, ov[d], c8[d], ir[d]);
      end
      @(negedge clk);
      rst = 1'b1;
      run8(d, 8'h03, 8'h05, 1'b0, 1'b1, p, lat);
      n_cmp++;
      if (p !== 16'h000F || lat != nit(d) + 1) begin
        n_err++;
        $display("FAIL rst_next d%0d: c=%h lat=%0d want 000f/%0d", d, p, lat, nit(d) + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t_prev, t_now, k;
    logic stray;
    for (int d = 0; d < 2; d++) begin
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        a8[d] = bb[i].a; b8[d] = bb[i].b; sg[d] = bb[i].s;
        iv[d] = 1'b1; ordy[d] = 1'b1;
        k = 0;
        while (ir[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        t_now = cyc;
        if (i > 0) begin
          n_cmp++;
          if (t_now - t_prev != nit(d) + 2) begin
            n_err++;
            $display("FAIL b2b_spacing d%0d op%0d: got %0d want %0d",
                     d, i, t_now - t_prev, nit(d) + 2);
          end
        end
        t_prev = t_now;
        @(posedge clk); #1;
        k = 0;
        while (ov[d] !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
        n_cmp++;
        if (ov[d] !== 1'b1 || c8[d] !== bb[i].p) begin
          n_err++;
          $display("FAIL b2b_value d%0d op%0d: ov=%b c=%h want 1/%h", d, i, ov[d], c8[d], bb[i].p);
        end
      end
      @(negedge clk);
      iv[d] = 1'b0;
      stray = 1'b0;
      @(posedge clk); #1;
      repeat (nit(d) + 4) begin
        @(posedge clk); #1;
        if (ov[d] !== 1'b0) stray = 1'b1;
      end
      n_cmp++;
      if (stray) begin
        n_err++;
        $display("FAIL b2b_extra d%0d: out_valid=1 after last op, want 0", d);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic s;
    logic signed [15:0] sa, sb;
    logic [15:0] e, p;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        s = 1'($urandom);
        sa = $signed(a);
        sb = $signed(b);
        if (s) e = sa * sb;
        else   e = {8'h0, a} * {8'h0, b};
        run8(d, a, b, s, 1'b1, p, lat);
        n_cmp++;
        if (p !== e || lat != nit(d) + 1) begin
          n_err++;
          $display("FAIL rand d%0d: %h*%h s=%b c=%h lat=%0d want %h/%0d",
                   d, a, b, s, p, lat, e, nit(d) + 1);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [520:0]  a, b;
    logic [1041:0] e, p;
    int lat;
    for (int d = 2; d < 4; d++) begin
      for (int t = 0; t < 3; t++) begin
        e = '0;
        if (t == 0) begin
          a = '1; b = '1;
          for (int i = 522; i < 1042; i++) e[i] = 1'b1;
          e[0] = 1'b1;
          runw(d, a, b, 1'b0, p, lat);
        end else if (t == 1) begin
          a = '0; a[520] = 1'b1; b = a;
          e[1040] = 1'b1;
          runw(d, a, b, 1'b1, p, lat);
        end else begin
          a = '1; b = '1;
          e[0] = 1'b1;
          runw(d, a, b, 1'b1, p, lat);
        end
        n_cmp++;
        if (p !== e) begin
          n_err++;
          $display("FAIL wide d%0d t%0d: c[1041:978]=%h c[63:0]=%h want %h/%h",
                   d, t, p[1041:978], p[63:0], e[1041:978], e[63:0]);
        end
        n_cmp++;
        if (lat != nit(d) + 1) begin
          n_err++;
          $display("FAIL wide_latency d%0d: got %0d want %0d", d, lat, nit(d) + 1);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; sg[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      a8[d] = '0; b8[d] = '0; aw[d] = '0; bw[d] = '0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_signed_corner();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
